// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the round-robin transmitter scheduler.
package tx_sched_pkg;

  localparam int DATA_W_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] reqDouble;
  logic [2*N_REQ-1:0] reqShift;
  logic [N_REQ-1:0]   reqRot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     idxSum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign reqDouble = {req, req};
  assign reqShift  = reqDouble >> ptr;
  assign reqRot    = reqShift[N_REQ-1:0];

  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        valid  = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  assign idxSum = {1'b0, ptr} + {1'b0, offset};
  assign idx    = (idxSum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(idxSum - (IDX_W+1)'(N_REQ))
                                                : IDX_W'(idxSum);

endmodule

// File: rtl/tx_sched.sv
// Round-robin scheduler sharing one serial transmitter between N_REQ requesters,
// with a watchdog on the transmitter's start acknowledge.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = DATA_W_DEFAULT,
  parameter  int ACK_TIMEOUT = 16,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_start_o,
  input  logic                    tx_busy_i,
  input  logic                    tx_done_i,
  output logic                    busy_o,
  output logic [IDX_W-1:0]        cur_id_o,
  output logic                    err_o
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  tx_sched_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  id_q, id_d;

  logic              arbValid;
  logic [IDX_W-1:0]  arbIdx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .valid (arbValid),
    .idx   (arbIdx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  // err_q is raised on the edge where the counter reaches its last value, so the
  // cycle showing err_o is the one that abandons the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (arbValid) begin
          data_d  = data_i[arbIdx*DATA_W +: DATA_W];
          id_d    = arbIdx;
          ptr_d   = (arbIdx == IDX_W'(N_REQ - 1)) ? '0 : arbIdx + IDX_W'(1);
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (err_q || tx_done_i) begin
          state_d = ST_IDLE;
        end else if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          err_d = ((cnt_q + CNT_W'(1)) == CNT_LAST);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o      = '0;
    tx_start_o = (state_q == ST_START);
    busy_o     = (state_q != ST_IDLE);
    if (state_q == ST_START) gnt_o[id_q] = 1'b1;
  end

  assign tx_data_o = data_q;
  assign cur_id_o  = id_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_tx_sched.sv
// Directed self-checking bench for tx_sched; the transmitter handshake is driven by hand.
module tb_tx_sched;

  localparam int N_REQ       = 4;
  localparam int DATA_W      = 9;
  localparam int ACK_TIMEOUT = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       txData;
  logic                    txStart;
  logic                    txBusy;
  logic                    txDone;
  logic                    busyO;
  logic [1:0]              curId;
  logic                    errO;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] words [N_REQ];

  always #5 clk = ~clk;

  tx_sched #(
    .N_REQ       (N_REQ),
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .data_i     (data),
    .gnt_o      (gnt),
    .tx_data_o  (txData),
    .tx_start_o (txStart),
    .tx_busy_i  (txBusy),
    .tx_done_i  (txDone),
    .busy_o     (busyO),
    .cur_id_o   (curId),
    .err_o      (errO)
  );

  // Inputs are presented for the cycle ending at the next edge; outputs are read 1 time unit later.
  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic b, input logic d);
    req    = r;
    txBusy = b;
    txDone = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One short frame: grant, then done one cycle into WAIT_BUSY, with requests held at r.
  task automatic runFrame(input logic [N_REQ-1:0] r, input int idx, input string tag);
    logic [N_REQ-1:0] oneHot;
    oneHot = 4'b0001 << idx;
    applyStimulus(r, 1'b0, 1'b0);
    checkOutput({tag, "_start"}, txStart, 1);
    checkOutput({tag, "_gnt"}, gnt, oneHot);
    checkOutput({tag, "_id"}, curId, idx);
    checkOutput({tag, "_data"}, txData, words[idx]);
    applyStimulus(r, 1'b0, 1'b0);
    checkOutput({tag, "_start_drop"}, txStart, 0);
    applyStimulus(r, 1'b0, 1'b1);
    checkOutput({tag, "_idle"}, busyO, 0);
  endtask

  initial begin
    words[0] = 9'h011;
    words[1] = 9'h0A2;
    words[2] = 9'b100111100;
    words[3] = 9'h1F3;
    data   = {words[3], words[2], words[1], words[0]};
    rst    = 1'b1;
    req    = 4'b1111;
    txBusy = 1'b0;
    txDone = 1'b0;

    // Reset held with every requester asking.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("rst_start", txStart, 0);
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_busy", busyO, 0);
    end
    checkOutput("rst_err", errO, 0);
    checkOutput("rst_data", txData, 0);
    checkOutput("rst_id", curId, 0);
    rst = 1'b0;
    checkOutput("rel_nostart", txStart, 0);
    runFrame(4'b1111, 0, "rel");

    // Single requester 2 with a transmitter that goes busy 2 cycles after start.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("single_gnt", gnt, 4'b0100);
    checkOutput("single_start", txStart, 1);
    checkOutput("single_data", txData, 9'h13C);
    checkOutput("single_id", curId, 2);
    checkOutput("single_busy", busyO, 1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("single_start_drop", txStart, 0);
    checkOutput("single_gnt_drop", gnt, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("single_busy_hold", busyO, 1);
      checkOutput("single_data_hold", txData, 9'h13C);
      checkOutput("single_no_err", errO, 0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("single_done_idle", busyO, 0);
    checkOutput("single_done_err", errO, 0);

    // Wrap priority: pointer sits after 3, so 0 wins, then 3.
    runFrame(4'b1000, 3, "wrap_first");
    runFrame(4'b1001, 0, "wrap_zero");
    runFrame(4'b1001, 3, "wrap_three");

    // Fairness: all requesters held for 8 frames.
    for (int i = 0; i < 8; i++) begin
      runFrame(4'b1111, i % 4, "fair");
    end

    // Watchdog: no busy/done ever; requester 1 waits behind the abandoned frame.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("wd_start", txStart, 1);
    checkOutput("wd_id", curId, 0);
    for (int k = 1; k <= ACK_TIMEOUT; k++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0);
      checkOutput("wd_err", errO, (k == ACK_TIMEOUT));
      checkOutput("wd_busy", busyO, 1);
    end
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("wd_err_drop", errO, 0);
    checkOutput("wd_idle", busyO, 0);
    checkOutput("wd_idle_start", txStart, 0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("wd_next_start", txStart, 1);
    checkOutput("wd_next_gnt", gnt, 4'b0010);
    checkOutput("wd_next_id", curId, 1);
    checkOutput("wd_next_data", txData, 9'h0A2);

    // Reset during WAIT_DONE drops the frame and rewinds the pointer.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("mid_busy", busyO, 1);
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("mid_idle", busyO, 0);
    checkOutput("mid_err", errO, 0);
    checkOutput("mid_data", txData, 0);
    checkOutput("mid_id", curId, 0);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("mid_ptr_gnt", gnt, 4'b0001);
    checkOutput("mid_ptr_id", curId, 0);
    checkOutput("mid_ptr_err", errO, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
# tx_sched

Round-robin scheduler that shares the single 9-bit serial transmitter (`tx_simple`) between `N_REQ` requesters. It captures one requester's word, launches one frame on the transmitter, and tracks that frame through the transmitter's busy/done handshake. It guards the launch with a start-acknowledge watchdog. It sits between the requester blocks and the transmitter; the transmitter itself is unchanged.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 9, frame payload width, equal to the transmitter `data_i` width
- `ACK_TIMEOUT`, 16, cycles allowed between `tx_start_o` and `tx_busy_i` rising (≥2)

- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, synchronous, active-high
- `req_i`  in  N_REQ  per-requester request level; held with data until granted
- `data_i`  in  N_REQ*DATA_W  requester k payload at bits [k*DATA_W +: DATA_W]
- `gnt_o`  out  N_REQ  one-hot, one-cycle pulse: word of requester k captured
- `tx_data_o`  out  DATA_W  registered word to transmitter `data_i`
- `tx_start_o`  out  1  one-cycle frame launch pulse
- `tx_busy_i`  in  1  transmitter shifting a frame
- `tx_done_i`  in  1  one-cycle pulse: frame finished (transmitter `ena_o`)
- `busy_o`  out  1  scheduler not in IDLE
- `cur_id_o`  out  $clog2(N_REQ)  index of the requester owning the current frame
- `err_o`  out  1  one-cycle pulse: watchdog expired, frame abandoned

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, with `|req_i`:
  - Winner k is the first set bit at or after `rr_ptr`, searching upward and wrapping.
  - At the edge: `tx_data_o` ← word k, `cur_id_o` ← k, `rr_ptr` ← (k+1) mod N_REQ, go to START.
- START:
  - `gnt_o[k]` = 1 and `tx_start_o` = 1 for this single cycle.
  - Watchdog counter cleared.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_done_i` = 1 → IDLE. This covers the transmitter finishing without a visible busy cycle.
  - Else `tx_busy_i` = 1 → WAIT_DONE.
  - Else counter increments. When the counter reaches `ACK_TIMEOUT`-1 → `err_o` pulse, go to IDLE. `rr_ptr` is not rolled back.
- WAIT_DONE: `tx_done_i` = 1 → IDLE. There is no timeout in this state; frame length is owned by the transmitter.
- Requests arriving outside IDLE are not lost: levels are held and sampled on return to IDLE.
- The granted requester drops `req_i` the cycle after `gnt_o`. If it keeps `req_i` high, that is a new request, arbitrated normally.
- `req_i` changes during START/WAIT_* have no effect on the frame in flight.

## Timing
- Values after reset:
  - State IDLE, `rr_ptr` = 0.
  - `gnt_o` = 0, `tx_start_o` = 0, `tx_data_o` = 0, `cur_id_o` = 0.
  - `busy_o` = 0, `err_o` = 0.
- Reset mid-frame: return to IDLE at the next edge and drop the frame with no `err_o`. The transmitter is reset by the same `rst_i`.
- Latency: request seen in IDLE at cycle n → `gnt_o`/`tx_start_o` high in cycle n+1.
- `tx_data_o` is stable from cycle n+1 until the next START. It is held while the transmitter shifts.
- Back-to-back: `tx_done_i` in cycle m → IDLE in m+1 → next START in m+2 at the earliest.
- `busy_o` is combinational from state (state ≠ IDLE); all other outputs are registered or direct state decodes.
- Watchdog: with `tx_busy_i` and `tx_done_i` both low, `err_o` fires exactly `ACK_TIMEOUT` cycles after the START cycle.

## Structure
- Package `tx_sched_pkg`: state enum `tx_sched_state_e`, `DATA_W` default constant.
- Sub-module `rr_arbiter`: combinational rotating-priority pick.
  - Inputs: `req`, `ptr`.
  - Outputs: `valid`, `idx`.
  - Parameterised by `N_REQ`.
- FSM, watchdog counter, `rr_ptr` and output registers live in `tx_sched`.

## Test plan
- Reset: hold `rst_i` 5 cycles with all `req_i` = 1 → all outputs 0, no `tx_start_o` until 1 cycle after release.
- Single requester:
  - Stimulus: `req_i` = 4'b0100, word 2 = 9'b100111100. Transmitter model: busy 2 cycles after start, done 20 cycles later.
  - Expect: `gnt_o` = 4'b0100 and `tx_start_o` next cycle, `tx_data_o` = 9'h13C, `cur_id_o` = 2, `busy_o` = 1 until 1 cycle after done.
- Fairness: all four requesters held high continuously → grant order 0,1,2,3,0,… over 8 frames, with no requester granted twice before the other three.
- Wrap priority: after a grant to 3, `req_i` = 4'b1001 → next grant to 0, then 3.
- Watchdog:
  - `ACK_TIMEOUT` = 16, transmitter model never asserts busy/done.
  - Expect `err_o` pulse exactly 16 cycles after `tx_start_o`, then IDLE.
  - A pending `req_i` = 4'b0010 is granted 2 cycles after `err_o`.
- Reset mid-frame: assert `rst_i` during WAIT_DONE → IDLE next edge, `busy_o` = 0, no `err_o`, `rr_ptr` = 0.
